// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op encoding, FSM states and the default datapath width.
package mds_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    // Two's complement magnitude; 0x80000000 maps to itself as unsigned 2^31.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the control sequencer and the unit.
// Master drives the request; slave returns status and the 64-bit C value.
interface mul_div_unit_if #(
    parameter int WIDTH = mds_pkg::WIDTH
);
    logic               start;
    logic               op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] c_out;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, c_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, c_out
    );
endinterface

// File: rtl/mul_div_unit_step.sv
// One radix-2 iteration: Booth add/sub + arithmetic shift for MUL,
// restoring shift/subtract on magnitudes for DIV.
module mul_div_step
    import mds_pkg::*;
#(
    parameter int WIDTH = mds_pkg::WIDTH
) (
    input  logic             i_op,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    // Next accumulator/quotient-register values for the selected op.
    always_comb begin
        w_sum  = i_acc;
        w_shl  = '0;
        w_diff = '0;
        o_acc  = i_acc;
        o_q    = i_q;
        o_q1   = 1'b0;
        if (i_op == OP_MUL) begin
            case ({i_q[0], i_q1})
                2'b01:   w_sum = i_acc + i_m;
                2'b10:   w_sum = i_acc - i_m;
                default: w_sum = i_acc;
            endcase
            o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
            o_q1  = i_q[0];
        end else begin
            w_shl  = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
            w_diff = w_shl - i_m;
            if (w_diff[WIDTH]) begin
                o_acc = w_shl;
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end else begin
                o_acc = w_diff;
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed 32x32 multiply / 32/32 divide feeding Zhigh/Zlow.
// Fixed 33-edge latency from the start edge to the done cycle.
module mul_div_unit
    import mds_pkg::*;
#(
    parameter int WIDTH = mds_pkg::WIDTH,
    parameter int CNT_W = mds_pkg::CNT_W
) (
    input  logic         clock,
    input  logic         clear,
    mul_div_unit_if.slave bus
);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH:0]       r_m;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_a;
    logic                 r_q1;
    logic                 r_op;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_bz;
    logic [2*WIDTH-1:0]   r_c;
    logic                 r_dbz;

    logic [WIDTH:0]       w_acc;
    logic [WIDTH-1:0]     w_q;
    logic                 w_q1;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_result;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .i_op  (r_op),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q1  (r_q1),
        .i_m   (r_m),
        .o_acc (w_acc),
        .o_q   (w_q),
        .o_q1  (w_q1)
    );

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state: start only counts in IDLE, RUN exits after the last iteration.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sign correction and divide-by-zero substitution applied in FIX.
    always_comb begin
        w_quot   = r_neg_q ? (~r_q + 1'b1) : r_q;
        w_rem    = r_neg_r ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_result = {w_rem, w_quot};
        if (r_op == OP_MUL)
            w_result = {r_acc[WIDTH-1:0], r_q};
        else if (r_bz)
            w_result = {r_a, {WIDTH{1'b1}}};
    end

    // Operand latch, iteration registers and held result.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_a     <= '0;
            r_q1    <= 1'b0;
            r_op    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bz    <= 1'b0;
            r_c     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_acc   <= '0;
                        r_q1    <= 1'b0;
                        r_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_neg_r <= bus.a[WIDTH-1];
                        r_bz    <= (bus.b == '0);
                        if (bus.op == OP_DIV) begin
                            r_q <= mag(bus.a);
                            r_m <= {1'b0, mag(bus.b)};
                        end else begin
                            r_q <= bus.a;
                            r_m <= {bus.b[WIDTH-1], bus.b};
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc;
                    r_q   <= w_q;
                    r_q1  <= w_q1;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_c   <= w_result;
                    r_dbz <= (r_op == OP_DIV) && r_bz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state == RUN) || (r_state == FIX);
    assign bus.done        = (r_state == DONE);
    assign bus.c_out       = r_c;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, handshake, signed results,
// divide-by-zero, overflow, ignored starts and asynchronous clear.
module tb_mul_div_unit;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mul_div_unit_if bus_if ();

    mul_div_unit dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input bit spam,
                          input logic [63:0] exp_c, input logic exp_dbz,
                          input logic [63:0] prev_c, input logic prev_dbz);
        int dones;
        int lat;
        dones = 0;
        lat   = 0;
        @(negedge clock);
        bus_if.start = 1'b1;
        bus_if.op    = op_i;
        bus_if.a     = a_i;
        bus_if.b     = b_i;
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
        bus_if.op    = ~op_i;
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
        chk({tag, "_busy_k1"}, {63'b0, bus_if.busy}, 64'd1);
        chk({tag, "_c_hold"}, bus_if.c_out, prev_c);
        chk({tag, "_dbz_hold"}, {63'b0, bus_if.div_by_zero}, {63'b0, prev_dbz});
        for (int n = 1; n <= 40; n++) begin
            if (spam && n <= 32) begin
                bus_if.start = 1'b1;
                bus_if.a     = $urandom;
                bus_if.b     = $urandom;
            end else begin
                bus_if.start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (bus_if.done) begin
                dones++;
                if (lat == 0) lat = n;
                chk({tag, "_busy_at_done"}, {63'b0, bus_if.busy}, 64'd0);
            end
        end
        bus_if.start = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_done_count"}, 64'(dones), 64'd1);
        chk({tag, "_c_out"}, bus_if.c_out, exp_c);
        chk({tag, "_dbz"}, {63'b0, bus_if.div_by_zero}, {63'b0, exp_dbz});
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.op    = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        #1;
        chk("rst_busy", {63'b0, bus_if.busy}, 64'd0);
        chk("rst_done", {63'b0, bus_if.done}, 64'd0);
        chk("rst_dbz", {63'b0, bus_if.div_by_zero}, 64'd0);
        chk("rst_c", bus_if.c_out, 64'd0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0,
               64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 64'd0, 1'b0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0,
               64'h4000_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               64'h0000_0000_0000_0001, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'h0000_0000_0000_0001, 1'b0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0,
               64'h0000_0001_FFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               64'h0000_0000_8000_0000, 1'b0, 64'h0000_0001_FFFF_FFFD, 1'b0);
        run_op("div_by_0", 1'b1, 32'h0000_1234, 32'd0, 1'b0,
               64'h0000_1234_FFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
        run_op("mul_after_dbz", 1'b0, 32'd3, 32'd4, 1'b0,
               64'd12, 1'b0, 64'h0000_1234_FFFF_FFFF, 1'b1);
        run_op("div_spam", 1'b1, 32'd100, 32'd7, 1'b1,
               64'h0000_0002_0000_000E, 1'b0, 64'd12, 1'b0);

        @(negedge clock);
        bus_if.start = 1'b1;
        bus_if.op    = 1'b0;
        bus_if.a     = 32'd5;
        bus_if.b     = 32'd6;
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        chk("clr_busy", {63'b0, bus_if.busy}, 64'd0);
        chk("clr_done", {63'b0, bus_if.done}, 64'd0);
        chk("clr_c", bus_if.c_out, 64'd0);
        chk("clr_dbz", {63'b0, bus_if.div_by_zero}, 64'd0);
        @(negedge clock);
        clear = 1'b0;

        run_op("mul_after_clr", 1'b0, 32'hFFFF_FFFB, 32'd6, 1'b0,
               64'hFFFF_FFFF_FFFF_FFE2, 1'b0, 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
